// File: rtl/cnn_mac_pipe.sv
// -----------------------------------------------------------------------------
// cnn_mac_pipe
// Pipelined signed multiply-accumulate engine for convolution / dense layers.
// Beats (activation x weight) are multiplied in a NUM_STAGE-deep product
// pipeline. Products are summed into a dot product that is framed by first/last
// flags. Each finished dot product is rescaled (round half toward +inf),
// saturated to OUT_W bits and presented on a valid/ready output register.
// A single global enable freezes the whole pipe while the output is blocked.
//
// Optional build macro: CNN_MAC_RELU_EN
//   defined   -> ReLU between rescale and saturation; out_ovf only on
//                positive saturation
//   undefined -> plain signed saturation
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  beat can be accepted this cycle (global enable)
//   in_a       in   [A_W]   signed activation
//   in_b       in   [B_W]   signed weight
//   in_first   in   beat starts a new dot product
//   in_last    in   beat ends the dot product
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   out_data   out  [OUT_W] rescaled, saturated result
//   out_ovf    out  out_data was saturated
// -----------------------------------------------------------------------------
module cnn_mac_pipe #(
    parameter int unsigned A_W       = 9,
    parameter int unsigned B_W       = 13,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OUT_W     = 13,
    parameter int unsigned SHIFT     = 7,
    parameter int unsigned NUM_STAGE = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned LS    = NUM_STAGE - 1;
    localparam int unsigned R_W   = ACC_W + 1 - SHIFT;
    localparam int unsigned CMP_W = ((R_W > OUT_W) ? R_W : OUT_W) + 1;

    // Rounding constant 2^(SHIFT-1), one bit wider than the accumulator.
    localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (SHIFT - 1);

    // Saturation bounds, sign-extended to the comparison width.
    localparam logic signed [CMP_W-1:0] SAT_MAX =
        {{(CMP_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN =
        {{(CMP_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // -------------------------------------------------------------------------
    // Global enable: everything stalls only while a result waits on the output.
    // -------------------------------------------------------------------------
    logic ce;
    logic out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic out_ovf_q, out_ovf_d;

    assign ce       = ~(out_valid_q & ~out_ready);
    assign in_ready = ce;

    // -------------------------------------------------------------------------
    // Input register.
    // -------------------------------------------------------------------------
    logic                  in_v_q;
    logic                  in_f_q;
    logic                  in_l_q;
    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_v_q <= 1'b0;
            in_f_q <= 1'b0;
            in_l_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (ce) begin
            in_v_q <= in_valid;
            in_f_q <= in_first;
            in_l_q <= in_last;
            a_q    <= in_a;
            b_q    <= in_b;
        end
    end

    // -------------------------------------------------------------------------
    // Product pipeline: full-width signed product, sign-extended to ACC_W.
    // Element 0 is the newest stage, element LS feeds the accumulator; the
    // truncating cast drops the oldest entry as the pipe shifts.
    // -------------------------------------------------------------------------
    logic signed [P_W-1:0]           prod_c;
    logic [NUM_STAGE-1:0][ACC_W-1:0] p_q;
    logic [NUM_STAGE-1:0]            pv_q;
    logic [NUM_STAGE-1:0]            pf_q;
    logic [NUM_STAGE-1:0]            pl_q;

    assign prod_c = P_W'(a_q) * P_W'(b_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            p_q  <= '0;
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
        end else if (ce) begin
            p_q  <= (NUM_STAGE * ACC_W)'({p_q, ACC_W'(prod_c)});
            pv_q <= NUM_STAGE'({pv_q, in_v_q});
            pf_q <= NUM_STAGE'({pf_q, in_f_q});
            pl_q <= NUM_STAGE'({pl_q, in_l_q});
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator: modulo 2^ACC_W, restarts on first, clears after last.
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0] p_last_c;
    logic             pv_last_c;
    logic             pf_last_c;
    logic             pl_last_c;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_sum_c;

    assign p_last_c  = p_q[LS];
    assign pv_last_c = pv_q[LS];
    assign pf_last_c = pf_q[LS];
    assign pl_last_c = pl_q[LS];

    always_comb begin
        acc_sum_c = pf_last_c ? p_last_c : (acc_q + p_last_c);
        acc_d     = acc_q;
        if (pv_last_c) begin
            acc_d = pl_last_c ? '0 : acc_sum_c;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
        end else if (ce) begin
            acc_q <= acc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Rescale: add half an LSB one bit wider so the add never wraps, then
    // arithmetic shift right.
    // -------------------------------------------------------------------------
    logic signed [ACC_W:0]   rnd_c;
    logic signed [R_W-1:0]   r_c;
    logic signed [CMP_W-1:0] r_ext_c;
    logic [OUT_W-1:0]        res_c;
    logic                    ovf_c;

    assign rnd_c   = {acc_sum_c[ACC_W-1], acc_sum_c} + RND;
    assign r_c     = R_W'(rnd_c >>> SHIFT);
    assign r_ext_c = CMP_W'(r_c);

    // Saturation (with optional ReLU in front of it).
    always_comb begin
        res_c = OUT_W'(r_ext_c);
        ovf_c = 1'b0;
`ifdef CNN_MAC_RELU_EN
        if (r_ext_c[CMP_W-1]) begin
            res_c = '0;
        end else if (r_ext_c > SAT_MAX) begin
            res_c = OUT_W'(SAT_MAX);
            ovf_c = 1'b1;
        end
`else
        if (r_ext_c > SAT_MAX) begin
            res_c = OUT_W'(SAT_MAX);
            ovf_c = 1'b1;
        end else if (r_ext_c < SAT_MIN) begin
            res_c = OUT_W'(SAT_MIN);
            ovf_c = 1'b1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Output register: a new result may replace a consumed one in one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (ce) begin
            if (pv_last_c && pl_last_c) begin
                out_valid_d = 1'b1;
                out_data_d  = res_c;
                out_ovf_d   = ovf_c;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_cnn_mac_pipe
// Scoreboard bench: the stimulus process feeds beats and, for every accepted
// last beat, pushes the expected result computed by an arithmetic dot-product
// model. A monitor pops and compares whenever an output transfer happens.
// -----------------------------------------------------------------------------
module tb_cnn_mac_pipe;

    localparam int unsigned A_W       = 9;
    localparam int unsigned B_W       = 13;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned OUT_W     = 13;
    localparam int unsigned SHIFT     = 7;
    localparam int unsigned NUM_STAGE = 2;

    typedef struct {
        int data;
        bit ovf;
    } exp_t;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    int     total = 0;
    int     bad   = 0;
    exp_t   exp_q[$];
    longint m_acc = 0;
    bit     rnd_ready = 1'b0;

    cnn_mac_pipe #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .SHIFT(SHIFT), .NUM_STAGE(NUM_STAGE)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_first (in_first),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Rescale / saturate a finished dot product with plain integer arithmetic.
    function automatic exp_t expect_of(input longint acc);
        exp_t   e;
        longint r;
        longint mx;
        longint mn;
        r  = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        mx = (longint'(1) << (OUT_W - 1)) - 1;
        mn = -(longint'(1) << (OUT_W - 1));
        e.ovf = 1'b0;
`ifdef CNN_MAC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > mx) begin
            r = mx;
            e.ovf = 1'b1;
        end else if (r < mn) begin
            r = mn;
            e.ovf = 1'b1;
        end
        e.data = int'(r);
        return e;
    endfunction

    function automatic void model_beat(input int a, input int b, input bit f, input bit l);
        longint p;
        p = longint'(a) * longint'(b);
        if (f) m_acc = p;
        else   m_acc = m_acc + p;
        // wrap to a signed ACC_W-bit accumulator
        m_acc = (m_acc << (64 - ACC_W)) >>> (64 - ACC_W);
        if (l) begin
            exp_q.push_back(expect_of(m_acc));
            m_acc = 0;
        end
    endfunction

    // Present one beat; entered and left at posedge+1.
    task automatic send_beat(input int a, input int b, input bit f, input bit l);
        int n;
        in_a     = A_W'(a);
        in_b     = B_W'(b);
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge ap_clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout got=0 exp=1 t=%0t", $time);
                break;
            end
        end
        if (in_ready) model_beat(a, b, f, l);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge ap_clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: compare every transfer, and check stability while stalled.
    initial begin
        exp_t e;
        bit   hold_prev;
        int   prev_data;
        bit   prev_ovf;
        hold_prev = 1'b0;
        prev_data = 0;
        prev_ovf  = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                hold_prev = 1'b0;
                continue;
            end
            if (hold_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'($signed(out_data)), prev_data);
                check("stall_ovf", int'(out_ovf), int'(prev_ovf));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'($signed(out_data)), 99999);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_ovf", int'(out_ovf), int'(e.ovf));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = int'($signed(out_data));
            prev_ovf  = out_ovf;
        end
    end

    // Random back-pressure driver.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int lat;
        int len;
        int a;
        int b;
        bit big;
        bit f;

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // reset state
        #3;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ovf", int'(out_ovf), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;
        idle(2);

        // single term and latency
        send_beat(3, 128, 1'b1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(negedge ap_clk);
            lat++;
        end
        check("latency", lat, int'(NUM_STAGE) + 2);
        wait_drain();

        // rounding: 1, 0, 0
        send_beat(1, 64, 1'b1, 1'b1);
        send_beat(1, 63, 1'b1, 1'b1);
        send_beat(-1, 64, 1'b1, 1'b1);
        wait_drain();

        // saturation both ways
        for (int k = 0; k < 4; k++) send_beat(255, 4095, k == 0, k == 3);
        for (int k = 0; k < 4; k++) send_beat(-256, 4095, k == 0, k == 3);
        wait_drain();

        // back-pressure: two frames, output held for a while
        out_ready = 1'b0;
        fork
            begin
                send_beat(2, 128, 1'b1, 1'b0);
                send_beat(5, 128, 1'b0, 1'b1);
                send_beat(-1, 256, 1'b1, 1'b0);
                send_beat(1, 128, 1'b0, 1'b1);
            end
            begin
                repeat (7) @(negedge ap_clk);
                check("bp_in_ready", int'(in_ready), 0);
                check("bp_out_valid", int'(out_valid), 1);
                check("bp_hold_data", int'($signed(out_data)), 7);
                @(posedge ap_clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // framing: acc cleared after last, next beat without first starts at 0
        send_beat(4, 128, 1'b1, 1'b1);
        send_beat(1, 128, 1'b0, 1'b1);
        wait_drain();

        // randomized frames with gaps and random back-pressure
        rnd_ready = 1'b1;
        for (int fr = 0; fr < 40; fr++) begin
            len = int'($urandom_range(1, 6));
            big = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++) begin
                if (big) begin
                    a = int'($urandom_range(0, 511)) - 256;
                    b = int'($urandom_range(0, 8191)) - 4096;
                end else begin
                    a = int'($urandom_range(0, 31)) - 16;
                    b = int'($urandom_range(0, 511)) - 256;
                end
                if (k == 0) f = ($urandom_range(0, 4) != 0);
                else        f = ($urandom_range(0, 9) == 0);
                send_beat(a, b, f, k == len - 1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // reset mid-frame with a saturated result held on the output
        out_ready = 1'b0;
        send_beat(255, 4095, 1'b1, 1'b1);
        send_beat(7, 128, 1'b1, 1'b0);
        send_beat(2, 128, 1'b0, 1'b0);
        send_beat(3, 128, 1'b0, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge ap_clk);
            lat++;
        end
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_ovf", int'(out_ovf), 1);
        @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_ovf", int'(out_ovf), 0);
        check("async_rst_data", int'(out_data), 0);
        exp_q.delete();
        m_acc     = 0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;
        idle(1);
        send_beat(6, 128, 1'b1, 1'b1);
        wait_drain();
        idle(4);
        check("idle_out_valid", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
